// File: rtl/oops_rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oops_rob_ctrl
//  Description : Reorder buffer controller for the OOPs Tomasulo core.
//                Circular buffer with multi-lane CDB completion, in-order
//                multi-slot commit and branch-mispredict flush/redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module oops_rob_ctrl #(
   parameter int IDX_LEN  = 4,
   parameter int LANES    = 7,
   parameter int COMMIT_W = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        alloc_valid,
   output logic                        alloc_ready,
   output logic [IDX_LEN-1:0]          alloc_idx,
   input  logic [4:0]                  alloc_dest_reg,
   input  logic [31:0]                 alloc_pc,
   input  logic                        alloc_br,
   input  logic                        alloc_pred,
   input  logic [31:0]                 alloc_b_imm,
   input  logic [LANES-1:0]            cdb_valid,
   input  logic [LANES*IDX_LEN-1:0]    cdb_tag,
   input  logic [LANES*32-1:0]         cdb_data,
   output logic [COMMIT_W-1:0]         commit_valid,
   output logic [COMMIT_W*IDX_LEN-1:0] commit_idx,
   output logic [COMMIT_W*5-1:0]       commit_dest_reg,
   output logic [COMMIT_W*32-1:0]      commit_data,
   output logic                        flush,
   output logic [31:0]                 flush_pc,
   output logic [IDX_LEN:0]            count,
   output logic                        empty,
   output logic                        full
);

   localparam int               DEPTH   = 2**IDX_LEN;
   localparam logic [IDX_LEN:0] C_DEPTH = (IDX_LEN+1)'(DEPTH);

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   logic [IDX_LEN:0]   head_q, head_d;
   logic [IDX_LEN:0]   tail_q, tail_d;
   logic [IDX_LEN:0]   ncommit;
   logic [DEPTH-1:0]   busy_q, rdy_q, br_q, pred_q;
   logic [4:0]         dest_q [DEPTH];
   logic [31:0]        pc_q   [DEPTH];
   logic [31:0]        imm_q  [DEPTH];
   logic [31:0]        val_q  [DEPTH];
   logic [IDX_LEN-1:0] slot;
   logic               stop;
   logic               alloc_fire;

   assign count       = tail_q - head_q;
   assign empty       = (count == '0);
   assign full        = (count == C_DEPTH);
   assign alloc_ready = !full;
   assign alloc_idx   = tail_q[IDX_LEN-1:0];
   assign alloc_fire  = alloc_valid && alloc_ready;

   // Commit selection: retire a contiguous run of ready entries from head,
   // stopping after the first mispredicted branch, which raises the redirect
   always_comb begin
      commit_valid    = '0;
      commit_idx      = '0;
      commit_dest_reg = '0;
      commit_data     = '0;
      flush           = 1'b0;
      flush_pc        = '0;
      ncommit         = '0;
      stop            = 1'b0;
      slot            = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         slot = head_q[IDX_LEN-1:0] + IDX_LEN'(k);
         if (!stop && busy_q[slot] && rdy_q[slot]) begin
            commit_valid[k]                     = 1'b1;
            commit_idx[k*IDX_LEN +: IDX_LEN]    = slot;
            commit_dest_reg[k*5 +: 5]           = dest_q[slot];
            commit_data[k*32 +: 32]             = val_q[slot];
            ncommit                             = ncommit + 1'b1;
            if (br_q[slot] && (val_q[slot][0] != pred_q[slot])) begin
               flush    = 1'b1;
               flush_pc = val_q[slot][0] ? (pc_q[slot] + imm_q[slot])
                                         : (pc_q[slot] + 32'd4);
               stop     = 1'b1;
            end
         end else begin
            stop = 1'b1;
         end
      end
   end

   // Next pointers: a flush collapses the buffer to the post-commit head
   always_comb begin
      head_d = head_q + ncommit;
      tail_d = tail_q;
      if (flush) begin
         tail_d = head_d;
      end else if (alloc_fire) begin
         tail_d = tail_q + 1'b1;
      end
   end

   // Pointer and entry status bits; later CDB lanes override earlier ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         busy_q <= '0;
         rdy_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         if (flush) begin
            busy_q <= '0;
            rdy_q  <= '0;
         end else begin
            for (int l = 0; l < LANES; l++) begin
               if (cdb_valid[l] && busy_q[cdb_tag[l*IDX_LEN +: IDX_LEN]]) begin
                  rdy_q[cdb_tag[l*IDX_LEN +: IDX_LEN]] <= 1'b1;
               end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
               if (commit_valid[k]) begin
                  busy_q[commit_idx[k*IDX_LEN +: IDX_LEN]] <= 1'b0;
                  rdy_q[commit_idx[k*IDX_LEN +: IDX_LEN]]  <= 1'b0;
               end
            end
            if (alloc_fire) begin
               busy_q[tail_q[IDX_LEN-1:0]] <= 1'b1;
               rdy_q[tail_q[IDX_LEN-1:0]]  <= 1'b0;
            end
         end
      end
   end

   // Entry payload: captured on allocation and CDB write, no reset needed
   always_ff @(posedge clk) begin
      if (rst_n && !flush) begin
         for (int l = 0; l < LANES; l++) begin
            if (cdb_valid[l] && busy_q[cdb_tag[l*IDX_LEN +: IDX_LEN]]) begin
               val_q[cdb_tag[l*IDX_LEN +: IDX_LEN]] <= cdb_data[l*32 +: 32];
            end
         end
         if (alloc_fire) begin
            dest_q[tail_q[IDX_LEN-1:0]] <= alloc_dest_reg;
            pc_q[tail_q[IDX_LEN-1:0]]   <= alloc_pc;
            br_q[tail_q[IDX_LEN-1:0]]   <= alloc_br;
            pred_q[tail_q[IDX_LEN-1:0]] <= alloc_pred;
            imm_q[tail_q[IDX_LEN-1:0]]  <= alloc_b_imm;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/oops_rob_ctrl.md
Name: oops_rob_ctrl

Overview:
- Parametrised reorder buffer controller for the OOPs Tomasulo core.
- Successor to the single-commit ROB entry format: configurable depth, CDB lane count and commit width, plus built-in branch-mispredict detection and flush generation.
- Sits between dispatch (allocation), the common data bus (completion) and the register file / fetch (commit / redirect).

Parameters:
- IDX_LEN, 4, ROB index width; depth DEPTH = 2**IDX_LEN.
- LANES, 7, number of CDB lanes (ALUs + D-cache).
- COMMIT_W, 2, maximum entries retired per cycle (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_ready  out  1  entry available (= !full)
- alloc_idx  out  IDX_LEN  index the next allocation receives (tail)
- alloc_dest_reg  in  5  architectural destination (0 = none)
- alloc_pc  in  32  instruction PC
- alloc_br  in  1  entry is a conditional branch
- alloc_pred  in  1  predicted taken
- alloc_b_imm  in  32  branch offset
- cdb_valid  in  LANES  per-lane valid
- cdb_tag  in  LANES*IDX_LEN  per-lane ROB index
- cdb_data  in  LANES*32  per-lane result; for branches, bit 0 = actual taken
- commit_valid  out  COMMIT_W  slot k retires this cycle
- commit_idx  out  COMMIT_W*IDX_LEN  ROB index per slot
- commit_dest_reg  out  COMMIT_W*5  destination per slot
- commit_data  out  COMMIT_W*32  value per slot
- flush  out  1  mispredict detected on a retiring branch
- flush_pc  out  32  redirect target
- count  out  IDX_LEN+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- **Storage:** circular buffer. head/tail are IDX_LEN+1 bits; the MSB is the wrap bit. Entry fields: dest_reg, pc, br, pred, b_imm, val, rdy, busy.
- **Reset** (rst_n=0 at posedge): head=tail=0; all busy=rdy=0. Outputs: count=0, empty=1, full=0, alloc_ready=1, alloc_idx=0, commit_valid=0, flush=0, flush_pc=0, commit_* data=0.
- **Allocate:** on alloc_valid && alloc_ready, write the entry at tail[IDX_LEN-1:0] with busy=1, rdy=0; tail++ (wraps modulo 2*DEPTH).
  - alloc_ready uses the registered count. Slots freed by a same-cycle commit are not reusable until the next cycle.
  - alloc_valid while full is ignored; no state change.
- **CDB write:** for each lane with cdb_valid, if entry[tag].busy then set val=data, rdy=1 at the next edge.
  - Writes to non-busy tags are ignored.
  - Two lanes with the same tag: the highest lane index wins.
  - A result becomes commit-eligible one cycle after its CDB write; there is no same-cycle bypass.
- **Commit** (combinational from registered state): slot k (k=0..COMMIT_W-1) refers to entry head+k.
  - commit_valid[k] = 1 iff slots 0..k are all busy && rdy, and no slot j<k is a mispredicted branch.
  - Mispredict: br && (val[0] != pred).
  - Committed entries clear busy/rdy; head advances by the number of valid slots.
  - Branch entries retire with dest_reg as allocated; dispatch supplies 0, which the register file ignores.
- **Flush:** if retiring slot k is a mispredicted branch, flush=1 in the same cycle. flush_pc = val[0] ? pc+b_imm : pc+4 (32-bit wrap).
  - At the edge: all entries clear busy/rdy; tail=head_next (head after this cycle's commits); count=0.
  - alloc and CDB writes in the flush cycle are discarded. alloc_ready stays as computed, but the allocation is dropped.
- **count:** tail-head (IDX_LEN+1 bits), registered.
  - Allocate and commit in the same cycle: count += alloc - ncommit.
- **Reset mid-operation:** rst_n dominates all events, including a pending flush.

Test Plan:
- **Reset:** rst_n low 2 cycles, then high -> count=0, empty=1, alloc_ready=1, alloc_idx=0, commit_valid=0, flush=0.
- **Fill:** 16 consecutive allocs with no CDB -> full=1, count=16, alloc_ready=0. A 17th alloc_valid leaves tail and count unchanged.
- **Multi-lane, multi-commit:** alloc idx0..2 (dest x5,x6,x7). One cycle: lane0 tag0 data 0x55, lane3 tag1 data 0xAA -> next cycle commit_valid=2'b11 with data {0xAA,0x55}, dest {6,5}; count 3->1; idx2 not committed.
- **In-order retirement:** complete idx2 before idx0 -> commit_valid=0 until idx0 is rdy. Then idx0 commits in slot0, idx1 (if rdy) in slot1, idx2 the following cycle.
- **Mispredict:** idx0 ALU rdy; idx1 branch pc=0x100, b_imm=0x20, pred=0, CDB data=1; idx2 pending -> commit_valid=2'b11, flush=1, flush_pc=0x120. Next cycle count=0, empty=1. A CDB write to idx2 afterwards is ignored.
- **Wrap and duplicate tag:** head=15, entries 15 and 0 rdy -> both commit in one cycle, head wraps to 1 with the wrap bit toggled. Separately, lanes 2 and 5 both carry tag 3 (data 0x22 and 0x55) -> entry 3 holds 0x55.
